priority_index_fifo: RTL

PRIORITY_INDEX_FIFO -- requirements
Module: priority_index_fifo

---
 rtl/priority_index_fifo_if.sv | 29 ++
 rtl/priority_index_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/priority_index_fifo_if.sv
// Handshake bundle for priority_index_fifo: upstream word pair and ready in,
// decoded head entry and drop counter out.
interface priority_index_fifo_if #(
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic             ready_i;
    logic             val_o;
    logic [IW-1:0]    left_idx_o;
    logic [IW-1:0]    right_idx_o;
    logic [IW:0]      span_o;
    logic             zero_o;
    logic             err_o;
    logic [7:0]       drop_cnt_o;

    modport master (
        output data_left_i, data_right_i, data_val_i, ready_i,
        input  val_o, left_idx_o, right_idx_o, span_o, zero_o, err_o, drop_cnt_o
    );

    modport slave (
        input  data_left_i, data_right_i, data_val_i, ready_i,
        output val_o, left_idx_o, right_idx_o, span_o, zero_o, err_o, drop_cnt_o
    );
endinterface

// File: rtl/priority_index_fifo.sv
// Decodes a pair of one-hot words into bit indices plus a span, and queues the
// result in a small circular FIFO that counts entries lost to overflow.
module priority_index_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    priority_index_fifo_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * IW + (IW + 1) + 2;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    // Index of the highest set bit; a clean one-hot word yields its only bit.
    function automatic logic [IW-1:0] hi_idx(input logic [WIDTH-1:0] w);
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (w[k]) idx = k[IW-1:0];
        end
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [WIDTH-1:0] w);
        return |(w & (w - WIDTH'(1)));
    endfunction

    // Only called with l >= r, so the difference never goes negative.
    function automatic logic [IW:0] calc_span(input logic [IW-1:0] l, input logic [IW-1:0] r);
        logic signed [IW+1:0] d;
        d = $signed({2'b00, l}) - $signed({2'b00, r}) + $signed((IW + 2)'(1));
        return d[IW:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [IW-1:0] l_idx_p0;
    logic [IW-1:0] r_idx_p0;
    logic [IW:0]   span_p0;
    logic          zero_p0;
    logic          err_p0;
    logic          vld_p0;
    logic          l_zero;
    logic          r_zero;
    logic [EW-1:0] entry_p0;

    assign l_zero   = ~|bus.data_left_i;
    assign r_zero   = ~|bus.data_right_i;
    assign l_idx_p0 = hi_idx(bus.data_left_i);
    assign r_idx_p0 = hi_idx(bus.data_right_i);
    assign vld_p0   = bus.data_val_i;

    always_comb begin
        span_p0 = '0;
        zero_p0 = 1'b0;
        err_p0  = multi_hot(bus.data_left_i) | multi_hot(bus.data_right_i);
        if (l_zero && r_zero) begin
            zero_p0 = 1'b1;
        end else if (l_zero || r_zero) begin
            err_p0 = 1'b1;
        end else if (l_idx_p0 < r_idx_p0) begin
            err_p0 = 1'b1;
        end else begin
            span_p0 = calc_span(l_idx_p0, r_idx_p0);
        end
    end

    assign entry_p0 = {l_idx_p0, r_idx_p0, span_p0, zero_p0, err_p0};

    // ---- stage boundary: decoded entry into FIFO storage ----
    logic [EW-1:0] mem_p1 [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    drop_cnt;
    logic          vld_p1;
    logic          do_read;
    logic          do_write;
    logic          do_drop;
    logic [EW-1:0] head_p1;

    assign vld_p1   = (count != '0);
    assign do_read  = vld_p1 & bus.ready_i;
    assign do_write = vld_p0 & ((count < FULL_CNT) | do_read);
    assign do_drop  = vld_p0 & (count == FULL_CNT) & ~do_read;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !do_read)      count <= count + 1'b1;
            else if (do_read && !do_write) count <= count - 1'b1;
            if (do_drop) drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // Storage is data only and deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (do_write) mem_p1[wr_ptr] <= entry_p0;
    end

    // Gating with valid keeps outputs at zero under reset without resetting storage.
    assign head_p1 = vld_p1 ? mem_p1[rd_ptr] : '0;

    assign bus.val_o       = vld_p1;
    assign bus.left_idx_o  = head_p1[EW-1 -: IW];
    assign bus.right_idx_o = head_p1[EW-1-IW -: IW];
    assign bus.span_o      = head_p1[IW+2:2];
    assign bus.zero_o      = head_p1[1];
    assign bus.err_o       = head_p1[0];
    assign bus.drop_cnt_o  = drop_cnt;
endmodule
